// File: rtl/uart_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_pkg
// Description : Shared state encoding and constants for the UART frame
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_frame_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CMD     = 3'd1;
    localparam logic [2:0] ST_LEN     = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_CHK     = 3'd4;
    localparam logic [2:0] ST_HOLD    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_CMD     = ST_CMD,
        S_LEN     = ST_LEN,
        S_PAYLOAD = ST_PAYLOAD,
        S_CHK     = ST_CHK,
        S_HOLD    = ST_HOLD
    } frame_state_t;

    localparam logic [7:0]  c_SYNC_BYTE     = 8'hA5;
    // Start + 8 data + stop bits per UART character.
    localparam int unsigned c_BITS_PER_CHAR = 10;

endpackage : uart_frame_pkg
`default_nettype wire

// File: rtl/uart_frame_ctrl_timeout.sv
`default_nettype none
// ============================================================================
// Module      : frame_timeout
// Description : Inter-byte gap counter; flags expiry after LIMIT idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_timeout #(
    parameter int unsigned LIMIT = 400
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned c_CW = $clog2(LIMIT + 1);

    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + c_CW'(1);
        end
    end

    // A clear in the same cycle (an arriving byte) always beats expiry.
    assign expire = en && !clr && (r_cnt == c_CW'(LIMIT - 1));

endmodule : frame_timeout
`default_nettype wire

// File: rtl/uart_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_ctrl
// Description : Assembles SYNC/CMD/LEN/payload/CHK frames from a UART byte
//               stream and holds each checked frame until acknowledged.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int unsigned           CLK_FREQ      = 50000000,
    parameter int unsigned           BAUDRATE      = 9600,
    parameter int unsigned           DATA_WIDTH    = 8,
    parameter int unsigned           MAX_LEN       = 16,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE     = DATA_WIDTH'(c_SYNC_BYTE),
    parameter int unsigned           TIMEOUT_BYTES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        rx_data,
    input  logic                         rx_ready,
    output logic                         frame_valid,
    output logic [DATA_WIDTH-1:0]        frame_cmd,
    output logic [$clog2(MAX_LEN+1)-1:0] frame_len,
    input  logic [$clog2(MAX_LEN)-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]        rd_data,
    input  logic                         frame_ack,
    output logic                         busy,
    output logic                         chk_err,
    output logic                         len_err,
    output logic                         timeout_err,
    output logic                         overrun
);

    localparam int unsigned           c_LW      = $clog2(MAX_LEN + 1);
    localparam int unsigned           c_IW      = $clog2(MAX_LEN);
    localparam int unsigned           c_LIMIT   = TIMEOUT_BYTES * c_BITS_PER_CHAR * (CLK_FREQ / BAUDRATE);
    localparam logic [DATA_WIDTH-1:0] c_MAX_LEN = DATA_WIDTH'(MAX_LEN);

    frame_state_t          r_state;
    logic [DATA_WIDTH-1:0] r_cmd;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [c_LW-1:0]       r_len;
    logic [c_IW-1:0]       r_idx;
    logic [DATA_WIDTH-1:0] r_mem [MAX_LEN];

    logic w_idle_or_hold;
    logic w_expire;
    logic w_mem_we;

    assign w_idle_or_hold = (r_state == S_IDLE) || (r_state == S_HOLD);
    assign w_mem_we       = (r_state == S_PAYLOAD) && rx_ready;

    frame_timeout #(
        .LIMIT (c_LIMIT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clr    (rx_ready || w_idle_or_hold),
        .en     (!w_idle_or_hold),
        .expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_idx] <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= r_mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cmd       <= '0;
            r_acc       <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            frame_valid <= 1'b0;
            frame_cmd   <= '0;
            frame_len   <= '0;
            busy        <= 1'b0;
            chk_err     <= 1'b0;
            len_err     <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            chk_err     <= 1'b0;
            len_err     <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;

            if (w_expire) begin
                timeout_err <= 1'b1;
                busy        <= 1'b0;
                r_state     <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (rx_ready && (rx_data == SYNC_BYTE)) begin
                            busy    <= 1'b1;
                            r_state <= S_CMD;
                        end
                    end
                    S_CMD: begin
                        if (rx_ready) begin
                            r_cmd   <= rx_data;
                            r_acc   <= rx_data;
                            r_state <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (rx_ready) begin
                            if (rx_data > c_MAX_LEN) begin
                                len_err <= 1'b1;
                                busy    <= 1'b0;
                                r_state <= S_IDLE;
                            end else begin
                                r_len   <= c_LW'(rx_data);
                                r_acc   <= r_acc ^ rx_data;
                                r_idx   <= '0;
                                r_state <= (rx_data == '0) ? S_CHK : S_PAYLOAD;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (rx_ready) begin
                            r_acc <= r_acc ^ rx_data;
                            r_idx <= r_idx + c_IW'(1);
                            if (c_LW'(r_idx) == (r_len - c_LW'(1))) begin
                                r_state <= S_CHK;
                            end
                        end
                    end
                    S_CHK: begin
                        if (rx_ready) begin
                            busy <= 1'b0;
                            if (rx_data == r_acc) begin
                                frame_valid <= 1'b1;
                                frame_cmd   <= r_cmd;
                                frame_len   <= r_len;
                                r_state     <= S_HOLD;
                            end else begin
                                chk_err <= 1'b1;
                                r_state <= S_IDLE;
                            end
                        end
                    end
                    S_HOLD: begin
                        // The consumer owns the frame; incoming bytes are lost.
                        if (rx_ready) begin
                            overrun <= 1'b1;
                        end
                        if (frame_ack) begin
                            frame_valid <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end
                    default: begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule : uart_frame_ctrl
`default_nettype wire
